// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Load/store access controller between the core's serialiser and a data RAM
// with a req/ack handshake. One access at a time: a legal start launches a RAM
// request that is held until mem_ack or until the wait budget (TIMEOUT cycles
// of mem_req) runs out. Illegal starts are rejected in IDLE with an err pulse.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start           : single-cycle access request (is_store/func/byte_off
//                     sampled with it)
//   addr_in         : word address, wdata_in : store word
//   misaligned      : serialiser alignment fault flag
//   rdata_out       : registered load word (only loads update it)
//   busy/done/err   : status; done and err are one-cycle pulses
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata : RAM request bundle
//   mem_rdata/mem_ack                        : RAM response
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  func,
    input  logic [1:0]  byte_off,
    input  logic [9:0]  addr_in,
    input  logic [31:0] wdata_in,
    input  logic        misaligned,
    output logic [31:0] rdata_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic [7:0]  wait_cnt_reg;
    logic [31:0] rdata_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [3:0]  mem_be_reg;
    logic [9:0]  mem_addr_reg;
    logic [31:0] mem_wdata_reg;

    logic        illegal;
    logic [3:0]  store_be;
    logic [3:0]  be_next;

    // Per-lane store enable: byte selects the lane at byte_off, half selects
    // the lane pair picked by byte_off[1] (legal halves have byte_off[0]=0),
    // word selects every lane.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign store_be[gi] = (func[1:0] == 2'b00) ? (byte_off == 2'(gi)) :
                              (func[1:0] == 2'b01) ? (byte_off[1] == 1'(gi / 2)) :
                              1'b1;
    end

    // Loads always fetch the whole word; lane extraction happens downstream.
    assign be_next = is_store ? store_be : 4'b1111;

    always_comb begin
        illegal = 1'b0;
        if (misaligned)                                 illegal = 1'b1;
        if (func[1:0] == 2'b11)                         illegal = 1'b1;
        if (func[1:0] == 2'b01 && byte_off[0])          illegal = 1'b1;
        if (func[1:0] == 2'b10 && byte_off != 2'b00)    illegal = 1'b1;
        // Unsigned variants only exist for loads.
        if (is_store && func[2])                        illegal = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= 8'd0;
            rdata_reg     <= 32'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= 4'd0;
            mem_addr_reg  <= 10'd0;
            mem_wdata_reg <= 32'd0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (illegal) begin
                            err_reg <= 1'b1;
                        end else begin
                            state_reg    <= REQ;
                            busy_reg     <= 1'b1;
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= addr_in;
                            mem_we_reg   <= is_store;
                            mem_be_reg   <= be_next;
                            wait_cnt_reg <= 8'd0;
                            if (is_store) begin
                                mem_wdata_reg <= wdata_in;
                            end
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_reg   <= DONE;
                        mem_req_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        if (!mem_we_reg) begin
                            rdata_reg <= mem_rdata;
                        end
                    end else if (wait_cnt_reg == TIMEOUT_M1) begin
                        // Budget exhausted: abandon the access, keep rdata.
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        mem_req_reg <= 1'b0;
                        err_reg     <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg   <= IDLE;
                    busy_reg    <= 1'b0;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rdata_out = rdata_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_be    = mem_be_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule
